// File: rtl/ps2_host_tx.sv
// Purpose : PS/2 host-to-device transmitter; sends one command byte to the
//           device by driving the clock and data lines through pull-low
//           enables (open drain).
// Latency : INHIBIT_CYCLES of clock inhibit, then one cycle of data-low
//           setup. After that the frame follows the device clock: 10 bits
//           plus the ACK slot. done/error is a 1-cycle pulse on return to IDLE.
// Backpressure: tx_ready is high only in IDLE. tx_valid is ignored while a
//           frame is in flight, and tx_data is sampled only on accept.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready  command byte handshake (accept = valid & ready)
//   tx_done, tx_error          result pulses (ACK received / NACK or timeout)
//   busy                       high while a frame is in progress, through the result pulse
//   ps2_clk_in, ps2_data_in    raw, asynchronous line levels
//   ps2_clk_oe, ps2_data_oe    1 = pull the line low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_BITS   = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  // The abort decision is taken when the counter holds all-ones minus one.
  // As a result, the error pulse appears in the cycle in which the counter
  // holds all-ones.
  localparam logic [TIMEOUT_BITS-1:0] WD_ABORT = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SEND,
    ACK_WAIT,
    ACK_END
  } state_t;

  state_t                  state, state_nxt;
  logic                    clk_s1, clk_s2, clk_s3;
  logic                    data_s1, data_s2;
  logic                    fall;
  logic [9:0]              shift, shift_nxt;
  logic [3:0]              bit_cnt, bit_cnt_nxt;
  logic [INH_W-1:0]        inh_cnt, inh_cnt_nxt;
  logic [TIMEOUT_BITS-1:0] wd, wd_nxt;
  logic                    clk_oe_q, clk_oe_nxt;
  logic                    data_oe_q, data_oe_nxt;
  logic                    done_q, done_nxt;
  logic                    err_q, err_nxt;
  logic                    accept;

  assign tx_ready    = (state == IDLE);
  assign accept      = tx_valid & tx_ready;
  assign fall        = clk_s3 & ~clk_s2;
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign busy        = (state != IDLE) | done_q | err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      // Synchronisers reset to the idle (high) line level so that leaving
      // reset never looks like a clock fall.
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_s3    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      wd        <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_s1    <= ps2_clk_in;
      clk_s2    <= clk_s1;
      clk_s3    <= clk_s2;
      data_s1   <= ps2_data_in;
      data_s2   <= data_s1;
      shift     <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      inh_cnt   <= inh_cnt_nxt;
      wd        <= wd_nxt;
      clk_oe_q  <= clk_oe_nxt;
      data_oe_q <= data_oe_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    inh_cnt_nxt = inh_cnt;
    wd_nxt      = wd;
    clk_oe_nxt  = clk_oe_q;
    data_oe_nxt = data_oe_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          // Stop bit, odd parity, then data; bit 0 goes out first.
          shift_nxt   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_nxt = '0;
          inh_cnt_nxt = '0;
          wd_nxt      = '0;
          clk_oe_nxt  = 1'b1;
          // With a single inhibit cycle, that cycle is also the start-bit cycle.
          data_oe_nxt = (INHIBIT_CYCLES == 1);
          state_nxt   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          clk_oe_nxt = 1'b0;
          state_nxt  = RELEASE;
        end else begin
          inh_cnt_nxt = inh_cnt + 1'b1;
          // The start bit is registered so that it is on the pin during
          // the last inhibit cycle.
          if (inh_cnt == INH_PRE) begin
            data_oe_nxt = 1'b1;
          end
        end
      end

      RELEASE: begin
        wd_nxt    = '0;
        state_nxt = SEND;
      end

      SEND, ACK_WAIT, ACK_END: begin
        if (fall) begin
          wd_nxt = '0;
        end else begin
          wd_nxt = wd + 1'b1;
        end

        if (state == SEND) begin
          if (fall) begin
            data_oe_nxt = ~shift[bit_cnt];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state_nxt = ACK_WAIT;
            end
          end
        end else if (state == ACK_WAIT) begin
          if (fall) begin
            if (data_s2) begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = ACK_END;
            end
          end
        end else begin
          // The device must release both lines before the frame counts as done.
          if (clk_s2 && data_s2) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end

        // A watchdog abort overrides everything else and releases both lines.
        if (!fall && wd == WD_ABORT) begin
          data_oe_nxt = 1'b0;
          done_nxt    = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end

      default: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Purpose : randomized, scoreboard-checked bench for ps2_host_tx with an
//           open-drain line model and a behavioural PS/2 device.
// Latency : none (bench).
// Backpressure: stimulus waits on tx_ready before it offers the next byte.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TB   = 8;
  localparam int HALF = 20;

  localparam int M_ACK  = 0;
  localparam int M_NACK = 1;
  localparam int M_TO   = 2;
  localparam int M_RST  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain wiring: a line is low if either side pulls it low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_BITS(TB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cur_mode = M_ACK;
  int         rel_cyc = 0;
  int         fall11_cyc = 0;
  int         pulse_cnt = 0;
  bit         dev_busy = 1'b0;
  bit         dev_rst4 = 1'b0;
  logic [9:0] exp_frame_q[$];
  int         exp_res_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference frame: data LSB first, then a parity bit that makes the total
  // count of ones odd, then a stop bit of 1.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  // Device model: measures the inhibit, checks the start bit, clocks the
  // frame, samples each bit on the rising edge and answers in the ACK slot.
  initial begin : device
    logic [9:0] obs;
    logic [9:0] expf;
    int         inh;
    int         m;
    int         npulse;
    bit         prev_doe;
    obs = '0;
    forever begin
      @(negedge clk);
      if (reset || !ps2_clk_oe) continue;
      dev_busy = 1'b1;
      inh = 0;
      prev_doe = 1'b0;
      while (ps2_clk_oe && inh < 1000) begin
        inh++;
        prev_doe = ps2_data_oe;
        @(negedge clk);
      end
      chk(inh == INH, "inhibit_len", inh, INH);
      chk(prev_doe && ps2_data_oe, "start_bit_setup", {prev_doe, ps2_data_oe}, 3);
      rel_cyc = cyc;
      m = cur_mode;
      if (m == M_TO) begin
        dev_busy = 1'b0;
        continue;
      end
      npulse = (m == M_RST) ? 4 : 11;
      repeat (HALF) @(negedge clk);
      for (int i = 1; i <= npulse; i++) begin
        dev_clk_low = 1'b1;
        if (i == 11) fall11_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) obs[i-1] = ps2_data_in;
        if (i == 10) begin
          chk(exp_frame_q.size() != 0, "frame_expected", exp_frame_q.size(), 1);
          if (exp_frame_q.size() != 0) begin
            expf = exp_frame_q.pop_front();
            chk(obs == expf, "frame_bits", obs, expf);
          end
          if (m == M_ACK) dev_data_low = 1'b1;
        end
        if (i == 4 && m == M_RST) begin
          dev_rst4 = 1'b1;
          break;
        end
        if (i == 11) begin
          if (m == M_ACK) begin
            repeat (4) @(negedge clk);
            dev_data_low = 1'b0;
          end
          break;
        end
        repeat (HALF) @(negedge clk);
      end
      dev_busy = 1'b0;
    end
  end

  // Result monitor: pops one expected outcome per done/error pulse.
  initial begin : monitor
    int k;
    forever begin
      @(negedge clk);
      if (!reset && (tx_done || tx_error)) begin
        pulse_cnt++;
        chk(!(tx_done && tx_error), "pulse_exclusive", {tx_done, tx_error}, 1);
        chk(tx_ready && busy && !ps2_clk_oe && !ps2_data_oe, "pulse_status",
            {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1100);
        chk(exp_res_q.size() != 0, "unexpected_pulse", {tx_done, tx_error}, 0);
        if (exp_res_q.size() != 0) begin
          k = exp_res_q.pop_front();
          chk(tx_error == (k != M_ACK), "result_kind", {tx_done, tx_error}, (k == M_ACK) ? 2 : 1);
          if (k == M_TO)
            chk(cyc - rel_cyc == 2 ** TB, "timeout_cycle", cyc - rel_cyc, 2 ** TB);
          if (k == M_NACK)
            chk(cyc > fall11_cyc && cyc - fall11_cyc <= 8, "nack_after_fall11", cyc - fall11_cyc, 3);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] b, input int m);
    if (m == M_ACK || m == M_NACK) exp_frame_q.push_back(frame_of(b));
    if (m != M_RST) exp_res_q.push_back(m);
  endtask

  task automatic send(input logic [7:0] b, input int m);
    int t;
    @(negedge clk);
    cur_mode = m;
    tx_data  = b;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk(tx_ready, "accept_ready", tx_ready, 1);
    push_exp(b, m);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    @(negedge clk);
    chk(busy && !tx_ready && ps2_clk_oe, "after_accept", {busy, tx_ready, ps2_clk_oe}, 3'b101);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(tx_ready && !dev_busy && exp_res_q.size() == 0) && t < 4000);
    chk(t < 4000, "frame_complete", t, 4000);
  endtask

  initial begin : stimulus
    int t;
    int p0;
    int m;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk(tx_ready && !busy, "reset_ready_busy", {tx_ready, busy}, 2'b10);
    chk(!tx_done && !tx_error, "reset_pulses", {tx_done, tx_error}, 0);
    chk(!ps2_clk_oe && !ps2_data_oe, "reset_lines", {ps2_clk_oe, ps2_data_oe}, 0);

    send(8'hED, M_ACK);  wait_idle();
    send(8'h01, M_ACK);  wait_idle();
    send(8'h00, M_ACK);  wait_idle();
    send(8'h5A, M_NACK); wait_idle();
    send(8'h3C, M_TO);   wait_idle();

    // Reset in the middle of a frame, after the fourth clock fall.
    dev_rst4 = 1'b0;
    send(8'hA5, M_RST);
    t = 0;
    while (!dev_rst4 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk(dev_rst4, "reach_fall4", dev_rst4, 1);
    chk(ps2_data_oe, "bit3_driven_low", ps2_data_oe, 1);
    p0 = pulse_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk(!ps2_clk_oe && !ps2_data_oe && tx_ready, "midframe_reset",
        {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk(pulse_cnt == p0, "no_pulse_after_reset", pulse_cnt - p0, 0);
    send(8'hFF, M_ACK); wait_idle();

    // tx_valid stays high while tx_data changes every cycle.
    @(negedge clk);
    cur_mode = M_ACK;
    tx_data  = 8'h3A;
    tx_valid = 1'b1;
    chk(tx_ready, "hold_first_ready", tx_ready, 1);
    push_exp(8'h3A, M_ACK);
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!tx_ready) tx_data = 8'($urandom);
    end while (!tx_ready && t < 4000);
    chk(tx_ready && tx_done, "second_accept_at_done", {tx_ready, tx_done}, 3);
    push_exp(tx_data, M_ACK);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_idle();

    for (int r = 0; r < 12; r++) begin
      m = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
      send(8'($urandom), m);
      wait_idle();
    end

    chk(exp_frame_q.size() == 0, "frames_drained", exp_frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
